// File: rtl/dnn_pkg.sv
// dnn_pkg
//   Shared types and constants for the DNN classification stage.
//   - NUM_CLASSES    : number of output scores produced by the inference core
//   - DNN_DATA_WIDTH : width of each signed score
//   - argmax_state_t : control states of the argmax stage
package dnn_pkg;

  localparam int NUM_CLASSES    = 10;
  localparam int DNN_DATA_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/dnn_argmax_update.sv
// dnn_argmax_update
//   Combinational running-maximum step for one score of the argmax scan.
//   Ports:
//     x           in   signed score currently being examined
//     i           in   index of x
//     best        in   best score seen so far
//     second      in   runner-up score seen so far
//     best_idx    in   index of best
//     best_nx     out  updated best
//     second_nx   out  updated runner-up
//     best_idx_nx out  updated index of best
module dnn_argmax_update #(
  parameter int DATA_WIDTH = 5,
  parameter int IDX_WIDTH  = 4
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic        [IDX_WIDTH-1:0]  i,
  input  logic signed [DATA_WIDTH-1:0] best,
  input  logic signed [DATA_WIDTH-1:0] second,
  input  logic        [IDX_WIDTH-1:0]  best_idx,
  output logic signed [DATA_WIDTH-1:0] best_nx,
  output logic signed [DATA_WIDTH-1:0] second_nx,
  output logic        [IDX_WIDTH-1:0]  best_idx_nx
);

  // Strict '>' keeps the earliest index on a tie; an equal score still
  // lands in second so a tie yields a zero margin.
  always_comb begin
    best_nx     = best;
    second_nx   = second;
    best_idx_nx = best_idx;
    if (x > best) begin
      second_nx   = best;
      best_nx     = x;
      best_idx_nx = i;
    end else if (x > second) begin
      second_nx = x;
    end
  end

endmodule

// File: rtl/dnn_argmax_fix.sv
// dnn_argmax_fix
//   Argmax stage behind the fixed-point DNN core. Snapshots all scores on the
//   rising edge of in_valid, scans them one per cycle and presents the winning
//   class, its score and the margin over the runner-up with valid/ready.
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous active-low reset
//     clear       in   synchronous abort; drops the result and clears overrun
//     in_valid    in   core done (level, start on rising edge)
//     in_data     in   NUM_CLASSES packed signed scores, index 0 in the LSBs
//     out_ready   in   consumer accepts the result
//     out_valid   out  result available
//     class_idx   out  index of the maximum score
//     class_score out  maximum score
//     margin      out  best minus second-best (unsigned, one bit wider)
//     busy        out  stage is not idle
//     overrun     out  sticky: a start arrived while busy and was dropped
module dnn_argmax_fix #(
  parameter int DATA_WIDTH  = dnn_pkg::DNN_DATA_WIDTH,
  parameter int NUM_CLASSES = dnn_pkg::NUM_CLASSES,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_data,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic signed [DATA_WIDTH-1:0]      class_score,
  output logic [DATA_WIDTH:0]               margin,
  output logic                              busy,
  output logic                              overrun
);

  import dnn_pkg::*;

  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]         LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

  argmax_state_t state, state_nx;

  logic                         in_valid_q;
  logic signed [DATA_WIDTH-1:0] scores [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]         scan_idx;
  logic signed [DATA_WIDTH-1:0] best, second;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic signed [DATA_WIDTH-1:0] best_nx, second_nx;
  logic [IDX_WIDTH-1:0]         best_idx_nx;
  logic [DATA_WIDTH:0]          margin_nx;
  logic                         start;
  logic                         last_elem;

  assign start     = in_valid & ~in_valid_q;
  assign last_elem = (scan_idx == LAST_IDX);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // Both operands are sign-extended by one bit; best >= second, so the
  // difference is always a non-negative value that fits the wider width.
  assign margin_nx = {best_nx[DATA_WIDTH-1], best_nx} - {second_nx[DATA_WIDTH-1], second_nx};

  dnn_argmax_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_update (
    .x           (scores[scan_idx]),
    .i           (scan_idx),
    .best        (best),
    .second      (second),
    .best_idx    (best_idx),
    .best_nx     (best_nx),
    .second_nx   (second_nx),
    .best_idx_nx (best_idx_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)     state_nx = SCAN;
      SCAN:    if (last_elem) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // Edge detector, score snapshot, scan datapath, result and overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid_q  <= 1'b0;
      scan_idx    <= '0;
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      class_idx   <= '0;
      class_score <= '0;
      margin      <= '0;
      overrun     <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) scores[k] <= '0;
    end else begin
      in_valid_q <= in_valid;

      if (state == IDLE && state_nx == SCAN) begin
        for (int k = 0; k < NUM_CLASSES; k++) scores[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
        scan_idx <= '0;
        best     <= MIN_SCORE;
        second   <= MIN_SCORE;
        best_idx <= '0;
      end

      if (state == SCAN && !clear) begin
        best     <= best_nx;
        second   <= second_nx;
        best_idx <= best_idx_nx;
        scan_idx <= scan_idx + 1'b1;
        // The last element's update is folded straight into the result.
        if (last_elem) begin
          class_idx   <= best_idx_nx;
          class_score <= best_nx;
          margin      <= margin_nx;
        end
      end

      if (clear) begin
        overrun <= 1'b0;
      end else if (start && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dnn_argmax_fix.sv
// tb_dnn_argmax_fix
//   Self-checking bench for dnn_argmax_fix: directed vector table, randomized
//   vectors against a reference argmax model, and handshake/overrun/clear/reset
//   sequences.
module tb_dnn_argmax_fix;

  localparam int DW = 5;
  localparam int NC = 10;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic [NC*DW-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic [IW-1:0]    class_idx;
  logic signed [DW-1:0] class_score;
  logic [DW:0]      margin;
  logic             busy;
  logic             overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [NC*DW-1:0]     data;
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] score;
    logic [DW:0]          margin;
  } vec_t;

  vec_t vectors [6];

  dnn_argmax_fix #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (NC),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .class_idx   (class_idx),
    .class_score (class_score),
    .margin      (margin),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*DW-1:0] pack_arr(input int s[NC]);
    logic [NC*DW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = DW'(s[k]);
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] pack10(input int a0, input int a1, input int a2,
                                              input int a3, input int a4, input int a5,
                                              input int a6, input int a7, input int a8,
                                              input int a9);
    int s[NC];
    s[0] = a0; s[1] = a1; s[2] = a2; s[3] = a3; s[4] = a4;
    s[5] = a5; s[6] = a6; s[7] = a7; s[8] = a8; s[9] = a9;
    return pack_arr(s);
  endfunction

  // Reference: winner is the first index holding the maximum; the runner-up
  // is the maximum over every other index.
  task automatic model(input int s[NC], output int e_idx, output int e_score, output int e_margin);
    int sec;
    e_idx = 0;
    for (int k = 1; k < NC; k++) if (s[k] > s[e_idx]) e_idx = k;
    e_score = s[e_idx];
    sec = -1000;
    for (int k = 0; k < NC; k++) if (k != e_idx && s[k] > sec) sec = s[k];
    e_margin = e_score - sec;
  endtask

  // One-cycle in_valid pulse carrying the given scores; returns in cycle 1.
  task automatic applyStimulus(input logic [NC*DW-1:0] data);
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles from the start event until out_valid, bounded.
  task automatic waitValid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic runVector(input string tag, input logic [NC*DW-1:0] data,
                           input int e_idx, input int e_score, input int e_margin);
    int lat;
    out_ready = 1'b1;
    applyStimulus(data);
    waitValid(lat);
    checkOutput({tag, " latency"}, lat, NC + 1);
    checkOutput({tag, " class_idx"}, int'(class_idx), e_idx);
    checkOutput({tag, " class_score"}, int'(class_score), e_score);
    checkOutput({tag, " margin"}, int'(margin), e_margin);
    tick();
    checkOutput({tag, " out_valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int s[NC];
    int e_idx, e_score, e_margin, lat, cnt, bad;
    logic [IW-1:0] h_idx;
    logic signed [DW-1:0] h_score;
    logic [DW:0] h_margin;

    vectors[0] = '{pack10(-3, 2, 6, 1, -16, 0, 5, 4, 3, -1), 4'd2, 5'sd6, 6'd1};
    vectors[1] = '{pack10(-3, 2, 7, 1, -16, 0, 5, 7, 3, -1), 4'd2, 5'sd7, 6'd0};
    vectors[2] = '{pack10(-16, -16, -16, -16, -16, -16, -16, -16, -16, 15), 4'd9, 5'sd15, 6'd31};
    vectors[3] = '{pack10(-16, -16, -16, -16, -16, -16, -16, -16, -16, -16), 4'd0, -5'sd16, 6'd0};
    vectors[4] = '{pack10(15, -16, -16, -16, -16, -16, -16, -16, -16, -16), 4'd0, 5'sd15, 6'd31};
    vectors[5] = '{pack10(15, 15, 15, 15, 15, 15, 15, 15, 15, 15), 4'd0, 5'sd15, 6'd0};

    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick(); tick(); tick();
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset class_idx", int'(class_idx), 0);
    checkOutput("reset class_score", int'(class_score), 0);
    checkOutput("reset margin", int'(margin), 0);
    #2 rst = 1'b1;
    tick();

    for (int v = 0; v < 6; v++)
      runVector($sformatf("table%0d", v), vectors[v].data, int'(vectors[v].idx),
                int'(vectors[v].score), int'(vectors[v].margin));

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < NC; k++)
        s[k] = (n % 2 == 0) ? int'($urandom_range(0, 31)) - 16 : int'($urandom_range(0, 3)) - 2;
      model(s, e_idx, e_score, e_margin);
      runVector($sformatf("rand%0d", n), pack_arr(s), e_idx, e_score, e_margin);
    end

    // Stalled consumer, overrun while holding, release and clear.
    out_ready = 1'b0;
    applyStimulus(vectors[0].data);
    waitValid(lat);
    checkOutput("stall latency", lat, NC + 1);
    h_idx = class_idx; h_score = class_score; h_margin = margin;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!out_valid || class_idx != h_idx || class_score != h_score || margin != h_margin) bad++;
    end
    checkOutput("stall unstable cycles", bad, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("hold event overrun", int'(overrun), 1);
    checkOutput("hold event out_valid", int'(out_valid), 1);
    checkOutput("hold event class_idx", int'(class_idx), 2);
    checkOutput("hold event class_score", int'(class_score), 6);
    checkOutput("hold event margin", int'(margin), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("accept out_valid", int'(out_valid), 0);
    checkOutput("accept busy", int'(busy), 0);
    checkOutput("accept overrun sticky", int'(overrun), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear overrun", int'(overrun), 0);

    // Start and acceptance in the same HOLD cycle.
    applyStimulus(vectors[1].data);
    waitValid(lat);
    checkOutput("same-cycle latency", lat, NC + 1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("same-cycle out_valid", int'(out_valid), 0);
    checkOutput("same-cycle busy", int'(busy), 0);
    checkOutput("same-cycle overrun", int'(overrun), 1);
    in_valid = 1'b0;
    tick();

    // Clear beats a start in IDLE; the held level must not restart later.
    clear    = 1'b1;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear+event overrun", int'(overrun), 0);
    checkOutput("clear+event busy", int'(busy), 0);
    tick();
    checkOutput("held level no restart", int'(busy), 0);
    in_valid = 1'b0;
    tick();

    // Level held for 50 cycles gives exactly one result.
    in_data   = vectors[0].data;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    checkOutput("held level handshakes", cnt, 1);
    checkOutput("held level overrun", int'(overrun), 0);

    // Reset in mid-scan after a large early score, then a clean run.
    applyStimulus(pack10(15, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("scan event overrun", int'(overrun), 1);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("midscan reset out_valid", int'(out_valid), 0);
    checkOutput("midscan reset busy", int'(busy), 0);
    checkOutput("midscan reset overrun", int'(overrun), 0);
    checkOutput("midscan reset class_idx", int'(class_idx), 0);
    checkOutput("midscan reset class_score", int'(class_score), 0);
    checkOutput("midscan reset margin", int'(margin), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    runVector("post-reset", vectors[0].data, 2, 6, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
